// File: rtl/pwm_duty_ctrl.sv
// Duty-command sequencer for the motor PWM: clamps processor requests, slews once per period, bumper ESTOP.
// Define DUTY_RAMP_EN to slew by RAMP_STEP per period; otherwise duty jumps to target at the first boundary.
module pwm_duty_ctrl #(
  parameter int PERIOD    = 400000,
  parameter int RAMP_STEP = 8,
  parameter int MIN_DUTY  = 128,
  parameter int MAX_DUTY  = 230
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic       bump,
  input  logic       bump_clear,
  output logic [7:0] duty,
  output logic       period_tick,
  output logic       busy,
  output logic       estop
);
  localparam int            CW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [7:0]    MIN8  = 8'(MIN_DUTY);
  localparam logic [7:0]    MAX8  = 8'(MAX_DUTY);
  localparam logic [7:0]    STEP8 = 8'(RAMP_STEP);
`ifdef DUTY_RAMP_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RAMP, ESTOP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [7:0]        target, duty_n, target_n, clamped, stepped;
  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic              boundary, xfer;

  assign boundary  = (cnt == LAST);
  assign cmd_ready = !bump && (state != ESTOP);
  assign xfer      = cmd_valid && cmd_ready;

  always_comb begin
    clamped = cmd_duty;
    if (cmd_duty < MIN8)      clamped = MIN8;
    else if (cmd_duty > MAX8) clamped = MAX8;
  end

  // 9-bit signed difference: a full step is taken only when it cannot overshoot.
  always_comb begin
    diff    = $signed({1'b0, target}) - $signed({1'b0, duty});
    mag     = diff[8] ? 9'(-diff) : 9'(diff);
    stepped = target;
    if (SLEW && (32'(mag) > RAMP_STEP))
      stepped = diff[8] ? (duty - STEP8) : (duty + STEP8);
  end

  // IDLE and RAMP share one path: a boundary step toward the old target, then retarget.
  always_comb begin
    state_n  = state;
    duty_n   = duty;
    target_n = target;
    if (bump) begin
      state_n  = ESTOP;
      duty_n   = MIN8;
      target_n = MIN8;
    end else if (state == ESTOP) begin
      if (bump_clear) state_n = IDLE;
    end else begin
      if (boundary) duty_n   = stepped;
      if (xfer)     target_n = clamped;
      state_n = (duty_n == target_n) ? IDLE : RAMP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      duty        <= MIN8;
      target      <= MIN8;
      period_tick <= 1'b0;
      busy        <= 1'b0;
      estop       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= boundary ? '0 : cnt + CW'(1);
      duty        <= duty_n;
      target      <= target_n;
      period_tick <= boundary;
      busy        <= (duty_n != target_n);
      estop       <= (state_n == ESTOP);
    end
  end
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl (PERIOD=16, RAMP_STEP=8); expectations follow DUTY_RAMP_EN.
module tb_pwm_duty_ctrl;
  localparam int PERIOD = 16;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, bump, bump_clear;
  logic       period_tick, busy, estop;
  logic [7:0] cmd_duty, duty;
  int         nchk = 0, npass = 0, ticks_seen = 0;

  pwm_duty_ctrl #(.PERIOD(PERIOD), .RAMP_STEP(8), .MIN_DUTY(128), .MAX_DUTY(230)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duty(cmd_duty), .bump(bump), .bump_clear(bump_clear), .duty(duty),
    .period_tick(period_tick), .busy(busy), .estop(estop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    if (obs == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    ticks_seen = 0;
    do begin
      @(negedge clk);
      ticks_seen++;
    end while (!period_tick && ticks_seen < 2 * PERIOD + 4);
    check({tag, "_tick"}, int'(period_tick), 1);
  endtask

  task automatic tick_chk(input string tag, input int d, input int b);
    wait_tick(tag);
    check({tag, "_duty"}, int'(duty), d);
    check({tag, "_busy"}, int'(busy), b);
  endtask

  task automatic settle(input string tag, input int d);
    for (int k = 0; k < 16; k++) begin
      wait_tick(tag);
      check({tag, "_range"}, int'(duty >= 8'd128 && duty <= 8'd230), 1);
      if (!busy) break;
    end
    check({tag, "_final"}, int'(duty), d);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_duty = 8'd0; bump = 1'b0; bump_clear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_duty", int'(duty), 128);
    check("rst_busy", int'(busy), 0);
    check("rst_estop", int'(estop), 0);
    check("rst_tick", int'(period_tick), 0);
    check("rst_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;

    // ramp 128 -> 160
    send(8'd160);
    check("s1_hold", int'(duty), 128);
    check("s1_busy", int'(busy), 1);
`ifdef DUTY_RAMP_EN
    tick_chk("s1a", 136, 1);
    tick_chk("s1b", 144, 1);
    tick_chk("s1c", 152, 1);
    tick_chk("s1d", 160, 0);
`else
    tick_chk("s1j", 160, 0);
`endif
    @(negedge clk);
    check("s1_pulse", int'(period_tick), 0);
    send(8'd160);
    check("s1_same", int'(busy), 0);

    // clamping
    send(8'd255);
    settle("s2hi", 230);
    send(8'd10);
    settle("s2lo", 128);

    // bumper stop mid-ramp
    send(8'd200);
`ifdef DUTY_RAMP_EN
    tick_chk("s3a", 136, 1);
    tick_chk("s3b", 144, 1);
    tick_chk("s3c", 152, 1);
`else
    tick_chk("s3j", 200, 0);
`endif
    @(negedge clk);
    bump = 1'b1;
    #1 check("s3_rdy_bump", int'(cmd_ready), 0);
    @(negedge clk);
    check("s3_duty", int'(duty), 128);
    check("s3_estop", int'(estop), 1);
    check("s3_busy", int'(busy), 0);
    bump_clear = 1'b1;
    @(negedge clk);
    bump_clear = 1'b0;
    check("s3_clr_ign", int'(estop), 1);
    bump = 1'b0;
    @(negedge clk);
    check("s3_hold", int'(estop), 1);
    check("s3_rdy_es", int'(cmd_ready), 0);
    bump_clear = 1'b1;
    @(negedge clk);
    bump_clear = 1'b0;
    check("s3_rel", int'(estop), 0);
    check("s3_rdy", int'(cmd_ready), 1);
    check("s3_duty2", int'(duty), 128);

    // retarget mid-ramp, partial last step
    send(8'd200);
`ifdef DUTY_RAMP_EN
    tick_chk("s4a", 136, 1);
    tick_chk("s4b", 144, 1);
    tick_chk("s4c", 152, 1);
    tick_chk("s4d", 160, 1);
    send(8'd140);
    tick_chk("s4e", 152, 1);
    tick_chk("s4f", 144, 1);
    tick_chk("s4g", 140, 0);
`else
    tick_chk("s4j", 200, 0);
    send(8'd140);
    tick_chk("s4k", 140, 0);
`endif

    // transfer on the boundary edge: step uses the old target
    wait_tick("s4_align");
    repeat (15) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_duty  = 8'd180;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("s4_bnd_tick", int'(period_tick), 1);
    check("s4_bnd_duty", int'(duty), 140);
    check("s4_bnd_busy", int'(busy), 1);
`ifdef DUTY_RAMP_EN
    tick_chk("s4h", 148, 1);
`else
    tick_chk("s4l", 180, 0);
`endif

    // synchronous reset mid-change
    send(8'd220);
    check("s5_pre_busy", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("s5_duty", int'(duty), 128);
    check("s5_busy", int'(busy), 0);
    check("s5_estop", int'(estop), 0);
    check("s5_tick", int'(period_tick), 0);
    wait_tick("s5_cnt");
    check("s5_cnt_len", ticks_seen, PERIOD);

    // bump beats cmd_valid; bump_clear blocks cmd_ready
    @(negedge clk);
    bump = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd200;
    #1 check("s5_rdy_bump", int'(cmd_ready), 0);
    @(negedge clk);
    bump = 1'b0; cmd_valid = 1'b0;
    check("s5_es", int'(estop), 1);
    check("s5_es_duty", int'(duty), 128);
    bump_clear = 1'b1; cmd_valid = 1'b1;
    #1 check("s5_rdy_clr", int'(cmd_ready), 0);
    @(negedge clk);
    bump_clear = 1'b0; cmd_valid = 1'b0;
    check("s5_rel", int'(estop), 0);
    check("s5_no_xfer", int'(busy), 0);
    tick_chk("s5_after", 128, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
Sequencer that owns the 8-bit duty command feeding the motor PWM generator. Accepts duty requests from the control processor over a valid/ready handshake, clamps them to the safe 50–90% window, and slews the output toward the target by a fixed step once per PWM period. Bumper-stop requests override the processor and force minimum duty until explicitly cleared. Sits between the processor register interface and the PWM generator's duty input.

Parameters:
PERIOD, 400000, PWM period in clk cycles; must equal the generator's period.
RAMP_STEP, 8, maximum duty change per period boundary, in duty LSBs.
MIN_DUTY, 128, lowest duty code (128/256 = 50%).
MAX_DUTY, 230, highest duty code (about 90%).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  processor duty request valid
cmd_ready  out  1  request accepted when high together with cmd_valid
cmd_duty  in  8  requested duty code
bump  in  1  bumper stop request, level, synchronous to clk
bump_clear  in  1  one-cycle pulse that releases emergency stop
duty  out  8  duty code to the PWM generator
period_tick  out  1  one-cycle pulse on the last cycle of each PWM period
busy  out  1  high while duty != target
estop  out  1  high while in ESTOP

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge of clk.
- Reset values: duty = MIN_DUTY, target = MIN_DUTY, period counter = 0, period_tick = 0, busy = 0, estop = 0, state = IDLE.
- Period counter runs 0..PERIOD-1 and wraps. period_tick is registered and is high for exactly one cycle, in the cycle after the counter reads PERIOD-1. Boundary events use the counter == PERIOD-1 condition.
- cmd_ready is combinational: !bump && state != ESTOP.
- Transfer: cmd_valid && cmd_ready at a clk edge.
  - target <= clamp(cmd_duty, MIN_DUTY, MAX_DUTY).
  - A transfer during RAMP retargets immediately. The ramp continues from the current duty and does not restart.
- States:
  - IDLE: duty == target, no pending change. Transfer with clamped value != duty -> RAMP. Transfer with equal value stays in IDLE.
  - RAMP: at each boundary, duty moves toward target by min(RAMP_STEP, |target - duty|). When duty reaches target -> IDLE on the same edge.
  - ESTOP: entered on any cycle bump = 1, from any state.
    - On the next edge: duty <= MIN_DUTY and target <= MIN_DUTY, without waiting for a boundary.
    - Stays in ESTOP while bump = 1. bump_clear is ignored while bump = 1.
    - bump_clear = 1 with bump = 0 -> IDLE.
- Outside ESTOP entry, duty changes only on boundary edges. The generator therefore never sees a mid-period change except on a stop.
- busy = registered (duty != target). estop = registered (state == ESTOP).
- Simultaneous events:
  - bump with cmd_valid: bump wins and the command is not accepted.
  - bump_clear with cmd_valid: cmd_ready stays 0 that cycle.
  - Transfer on a boundary edge: the step that edge uses the old target. The new target applies from the next boundary.
- Arithmetic: the difference is computed at 9 bits signed, so duty never overshoots or wraps. RAMP_STEP >= 256 behaves as a jump.
- Reset mid-ramp or mid-ESTOP returns all outputs to reset values on that edge.

Optional Feature:
Macro DUTY_RAMP_EN.
- Defined: slewing by RAMP_STEP per boundary as above.
- Undefined: RAMP applies the full remaining difference at the first boundary, so duty jumps to target within one period. All other behaviour, including ESTOP and clamping, is unchanged.

Test Plan:
1. Bench uses PERIOD=16, RAMP_STEP=8. Reset, then send cmd_duty=160 -> duty goes 128, 136, 144, 152, 160 on four successive boundaries; busy drops with the last step; state returns to IDLE.
2. cmd_duty=255, then 10 -> target clamps to 230, then 128; duty never leaves 128..230.
3. Ramp 128->200. At duty=152, assert bump -> next edge duty=128, estop=1, cmd_ready=0. A bump_clear pulse while bump=1 is ignored. Drop bump, then pulse bump_clear -> estop=0, IDLE, duty=128.
4. Ramp to 200 in progress, retarget to 140 when duty=160 -> next boundary duty=152, then 144, then 140 (partial step of 4).
5. Drive cmd_valid and bump in the same cycle -> no transfer, target stays 128. Then assert rst_n=0 mid-ramp -> duty=128, busy=0, and period counter=0 on that edge.
6. Build without DUTY_RAMP_EN, send cmd_duty=200 -> duty=200 at the first boundary.
